// File: rtl/ce_gen_pkg.sv
// ce_gen_pkg: mode encodings and FSM states shared by the ce pulse generator.
package ce_gen_pkg;
   localparam logic [1:0] MODE_CONT  = 2'd0;
   localparam logic [1:0] MODE_BURST = 2'd1;
   localparam logic [1:0] MODE_STEP  = 2'd2;
   localparam logic [1:0] MODE_TC    = 2'd3;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/ce_pulse_gen_rise_det.sv
// rise_det: single-bit rising-edge detector; history clears to 0 on clr.
module rise_det (
   input  logic clk,
   input  logic clr,
   input  logic d,
   output logic rise
);
   logic q;
   always_ff @(posedge clk or posedge clr)
      if (clr) q <= 1'b0;
      else q <= d;
   assign rise = d && !q;
endmodule

// File: rtl/ce_pulse_gen.sv
// ce_pulse_gen: programmable-rate ce strobe for counter chains, with
// continuous, burst, single-step and run-to-terminal-count modes.
module ce_pulse_gen
   import ce_gen_pkg::*;
#(
   parameter int PW          = 16,
   parameter int PERIOD_INIT = 50000,
   parameter int BW          = 8
) (
   input  logic          clk,
   input  logic          clr,
   input  logic          en,
   input  logic [1:0]    mode,
   input  logic          period_ld,
   input  logic [PW-1:0] period_di,
   input  logic [BW-1:0] burst_n,
   input  logic          start,
   input  logic          stop,
   input  logic          step,
   input  logic          tc_in,
   output logic          ce_out,
   output logic          busy,
   output logic          done
);
   state_t state, state_n;
   logic [PW-1:0] period_q, div_q, pm1, div_nx;
   logic [BW-1:0] cnt, cnt_src;
   logic [1:0] run_mode, cur_mode;
   logic start_r, stop_r, step_r, go, abort, fire, step_fire, last;
   rise_det u_start (.clk(clk), .clr(clr), .d(start), .rise(start_r));
   rise_det u_stop  (.clk(clk), .clr(clr), .d(stop),  .rise(stop_r));
   rise_det u_step  (.clk(clk), .clr(clr), .d(step),  .rise(step_r));
   // ce is registered from the divider's next value so the first pulse lands
   // exactly P cycles after the start edge, and P=1 strobes every cycle.
   always_comb begin
      pm1 = (period_q == '0) ? '0 : period_q - 1'b1;
      div_nx = (div_q == pm1) ? '0 : div_q + 1'b1;
      go = en && state == IDLE && start_r && !stop_r && mode != MODE_STEP;
      abort = en && state == RUN && stop_r;
      step_fire = en && state == IDLE && mode == MODE_STEP && step_r;
      fire = en && ((go && pm1 == '0) ||
                    (state == RUN && !abort && !period_ld && div_nx == pm1));
      cur_mode = go ? mode : run_mode;
      cnt_src = go ? burst_n : cnt;
      last = fire && ((cur_mode == MODE_BURST && cnt_src == BW'(1)) ||
                      (cur_mode == MODE_TC && tc_in));
      state_n = !en ? state :
                state == DONE ? IDLE :
                last ? DONE :
                go ? RUN :
                abort ? IDLE : state;
   end
   always_ff @(posedge clk or posedge clr)
      if (clr) begin
         state <= IDLE;
         ce_out <= 1'b0;
         busy <= 1'b0;
         done <= 1'b0;
         div_q <= '0;
         cnt <= '0;
         period_q <= PW'(PERIOD_INIT);
         run_mode <= MODE_CONT;
      end else begin
         state <= state_n;
         busy <= state_n == RUN;
         done <= en && state == DONE;
         ce_out <= fire || step_fire;
         if (period_ld) period_q <= period_di;
         if (go) begin
            div_q <= '0;
            run_mode <= mode;
         end else if (period_ld && state == RUN) div_q <= '0;
         else if (en && state == RUN) div_q <= div_nx;
         // a burst count of 0 wraps through 2^BW before reaching the last pulse
         if (go || fire) cnt <= cnt_src - BW'(fire);
      end
endmodule

// File: tb/tb_ce_pulse_gen.sv
// tb_ce_pulse_gen: randomized and directed checks of ce_pulse_gen against a
// pulse-index reference model.
module tb_ce_pulse_gen;
   localparam int PW = 16;
   localparam int BW = 8;
   localparam int PI = 7;
   logic clk = 1'b0, clr = 1'b1, en = 1'b0, period_ld = 1'b0;
   logic start = 1'b0, stop = 1'b0, step = 1'b0, tc_in;
   logic [1:0] mode = 2'd0;
   logic [PW-1:0] period_di = '0;
   logic [BW-1:0] burst_n = 8'd1;
   logic ce_out, busy, done;
   int vecs = 0, errs = 0;
   int ph, rmode, n, left, mper, seen, seen_done;
   logic ps, pp, pst, e_ce, e_busy, e_done;
   logic [3:0] ctr = 4'd0;
   assign tc_in = (ctr == 4'hf);
   always #5 clk = ~clk;
   ce_pulse_gen #(.PW(PW), .PERIOD_INIT(PI), .BW(BW)) dut (
      .clk(clk), .clr(clr), .en(en), .mode(mode), .period_ld(period_ld),
      .period_di(period_di), .burst_n(burst_n), .start(start), .stop(stop),
      .step(step), .tc_in(tc_in), .ce_out(ce_out), .busy(busy), .done(done)
   );
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic mreset;
      ph = 0; rmode = 0; n = 0; left = 0; mper = PI;
      ps = 1'b0; pp = 1'b0; pst = 1'b0;
      e_ce = 1'b0; e_busy = 1'b0; e_done = 1'b0;
   endtask
   // ph: 0 idle, 1 running, 2 done; n counts enabled cycles since start,
   // a pulse is due whenever n mod P equals P-1.
   task automatic mstep;
      int p;
      bit rs, rp, rt, due;
      rs = start && !ps; rp = stop && !pp; rt = step && !pst;
      ps = start; pp = stop; pst = step;
      p = (mper == 0) ? 1 : mper;
      e_ce = 1'b0; e_done = 1'b0; due = 1'b0;
      if (!en) begin
         if (ph == 1 && period_ld) n = 0;
      end else if (ph == 2) begin
         e_done = 1'b1; ph = 0;
      end else if (ph == 0) begin
         if (rs && !rp && mode != 2) begin
            ph = 1; rmode = mode; left = (burst_n == 0) ? 256 : int'(burst_n); n = 0;
            due = (n % p == p - 1);
         end else if (mode == 2 && rt) e_ce = 1'b1;
      end else if (rp) ph = 0;
      else if (period_ld) n = 0;
      else begin
         n++;
         due = (n % p == p - 1);
      end
      if (due) begin
         e_ce = 1'b1;
         left--;
         if ((rmode == 1 && left == 0) || (rmode == 3 && tc_in)) ph = 2;
      end
      if (period_ld) mper = int'(period_di);
      e_busy = (ph == 1);
   endtask
   task automatic tick;
      logic oc;
      oc = e_ce;
      mstep;
      @(posedge clk);
      #1;
      if (oc) ctr++;
      chk("ce_out", ce_out, e_ce);
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      seen += int'(ce_out);
      seen_done += int'(done);
   endtask
   task automatic load_period(input int p);
      period_ld = 1'b1; period_di = PW'(p);
      tick;
      period_ld = 1'b0;
   endtask
   task automatic go(input logic [1:0] m);
      mode = m; start = 1'b1; seen = 0; seen_done = 0;
      tick;
      start = 1'b0;
   endtask
   task automatic halt;
      stop = 1'b1;
      tick;
      stop = 1'b0;
      tick;
   endtask
   initial begin
      mreset;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ce", ce_out, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      clr = 1'b0; en = 1'b1;
      load_period(4);
      go(2'd0);
      repeat (12) tick;
      chk("cont_pulses", seen, 3);
      halt;
      repeat (6) tick;
      chk("cont_after_stop", seen, 3);
      load_period(3);
      burst_n = 8'd5;
      go(2'd1);
      repeat (20) tick;
      chk("burst_pulses", seen, 5);
      chk("burst_done", seen_done, 1);
      seen = 0;
      mode = 2'd2;
      for (int i = 0; i < 3; i++) begin
         step = 1'b1; tick; step = 1'b0;
         repeat (9) tick;
      end
      step = 1'b1;
      repeat (20) tick;
      step = 1'b0;
      tick;
      chk("step_pulses", seen, 4);
      ctr = 4'd0;
      load_period(2);
      go(2'd3);
      repeat (40) tick;
      chk("tc_pulses", seen, 16);
      chk("tc_ctr_wrap", ctr, 4'd0);
      chk("tc_done", seen_done, 1);
      load_period(4);
      go(2'd0);
      repeat (6) tick;
      en = 1'b0;
      repeat (7) tick;
      en = 1'b1;
      repeat (10) tick;
      chk("en_gap_pulses", seen, 4);
      halt;
      load_period(3);
      burst_n = 8'd5;
      go(2'd1);
      for (int i = 0; i < 30 && seen < 2; i++) tick;
      chk("clr_two_pulses", seen, 2);
      #2 clr = 1'b1;
      #1;
      chk("clr_ce", ce_out, 1'b0);
      chk("clr_busy", busy, 1'b0);
      chk("clr_done", done, 1'b0);
      mreset;
      @(posedge clk);
      #1 clr = 1'b0;
      seen = 0;
      repeat (10) tick;
      chk("clr_quiet", seen, 0);
      go(2'd0);
      repeat (20) tick;
      chk("init_period_pulses", seen, 3);
      halt;
      load_period(0);
      go(2'd0);
      repeat (9) tick;
      chk("p0_pulses", seen, 10);
      halt;
      load_period(1);
      burst_n = 8'd0;
      go(2'd1);
      repeat (260) tick;
      chk("burst256_pulses", seen, 256);
      chk("burst256_done", seen_done, 1);
      for (int i = 0; i < 3000; i++) begin
         en = ($urandom % 8) != 0;
         start = ($urandom % 5) == 0;
         stop = ($urandom % 40) == 0;
         step = ($urandom % 7) == 0;
         if ($urandom % 10 == 0) mode = 2'($urandom % 4);
         period_ld = ($urandom % 25) == 0;
         period_di = PW'($urandom % 6);
         burst_n = BW'(1 + $urandom % 6);
         tick;
      end
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
